// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store controller for a simple request/grant bus.
// Ports:
//   clk_i, rst                 clock, async active-high reset
//   execute_vaild_i, ED_*      instruction from execute (held while memory_ready_o=0)
//   write_back_allow_in_i      downstream may accept the memory-stage result
//   bus_req_o/we/addr/wdata/wstrb, bus_gnt_i, bus_rvalid_i, bus_rdata_i   data bus
//   memory_ready_o             result available (combinational in IDLE)
//   M_valM_o                   formatted load result (0 for stores / errors)
//   misalign_o                 misaligned or illegal access, no bus traffic (combinational)
//   bus_err_o                  access aborted by timeout, valid in DONE
module mem_access_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            execute_vaild_i,
    input  logic            ED_mem_rd_i,
    input  logic            ED_mem_wr_i,
    input  logic [XLEN-1:0] ED_addr_i,
    input  logic [XLEN-1:0] ED_wdata_i,
    input  logic [1:0]      ED_size_i,
    input  logic            ED_unsigned_i,
    input  logic            write_back_allow_in_i,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [3:0]      bus_wstrb_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            memory_ready_o,
    output logic [XLEN-1:0] M_valM_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int unsigned CNT_W = 8;
    // Last counter value before the abort fires: TIMEOUT cycles total in REQ+WAIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   valm_q, valm_d;
    logic              err_q, err_d;

    logic              misaligned;
    logic              mem_op;
    logic              timeout;
    logic              ready;
    logic              misalign;
    logic [XLEN-1:0]   rdata_sh;
    logic [XLEN-1:0]   load_fmt;
    logic [XLEN-1:0]   wdata_rep;
    logic [3:0]        wstrb_new;

    assign mem_op  = execute_vaild_i & (ED_mem_rd_i | ED_mem_wr_i);
    assign timeout = (cnt_q == CNT_LAST);

    // Alignment check on the incoming instruction.
    always_comb begin
        misaligned = 1'b0;
        unique case (ED_size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ED_addr_i[0];
            2'b10:   misaligned = |ED_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane replication and byte strobes from the incoming instruction.
    always_comb begin
        wdata_rep = ED_wdata_i;
        wstrb_new = 4'b1111;
        unique case (ED_size_i)
            2'b00: begin
                wdata_rep = {(XLEN/8){ED_wdata_i[7:0]}};
                wstrb_new = 4'b0001 << ED_addr_i[1:0];
            end
            2'b01: begin
                wdata_rep = {(XLEN/16){ED_wdata_i[15:0]}};
                wstrb_new = 4'b0011 << ED_addr_i[1:0];
            end
            default: begin
                wdata_rep = ED_wdata_i;
                wstrb_new = 4'b1111;
            end
        endcase
    end

    // Load formatting: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        rdata_sh = bus_rdata_i >> {off_q, 3'b000};
        load_fmt = bus_rdata_i;
        unique case (size_q)
            2'b00:   load_fmt = {{(XLEN-8){rdata_sh[7] & ~uns_q}}, rdata_sh[7:0]};
            2'b01:   load_fmt = {{(XLEN-16){rdata_sh[15] & ~uns_q}}, rdata_sh[15:0]};
            default: load_fmt = bus_rdata_i;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        valm_d   = valm_q;
        err_d    = err_q;
        ready    = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (mem_op) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        ready   = 1'b0;
                        off_d   = ED_addr_i[1:0];
                        size_d  = ED_size_i;
                        uns_d   = ED_unsigned_i;
                        we_d    = ED_mem_wr_i;
                        addr_d  = {ED_addr_i[XLEN-1:2], 2'b00};
                        wdata_d = wdata_rep;
                        wstrb_d = wstrb_new;
                        valm_d  = '0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Abort wins over a grant/rvalid arriving in the same cycle.
                if (timeout) begin
                    err_d   = 1'b1;
                    valm_d  = '0;
                    state_d = S_DONE;
                end else if (bus_gnt_i) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (bus_rvalid_i) begin
                        valm_d  = load_fmt;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    err_d   = 1'b1;
                    valm_d  = '0;
                    state_d = S_DONE;
                end else if (bus_rvalid_i) begin
                    valm_d  = load_fmt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ready = 1'b1;
                if (write_back_allow_in_i) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
        end
    end

    assign bus_req_o      = (state_q == S_REQ);
    assign bus_we_o       = we_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;
    assign bus_wstrb_o    = wstrb_q;
    assign memory_ready_o = ready;
    assign misalign_o     = misalign;
    assign M_valM_o       = valm_q;
    assign bus_err_o      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table-driven IDLE/store/load vectors plus
// hand-written sequences for timeout, hold in DONE and reset mid-access.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        execute_vaild_i, ED_mem_rd_i, ED_mem_wr_i, ED_unsigned_i;
    logic [31:0] ED_addr_i, ED_wdata_i;
    logic [1:0]  ED_size_i;
    logic        write_back_allow_in_i;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    logic        bus_req_o, bus_we_o, memory_ready_o, misalign_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, M_valM_o;
    logic [3:0]  bus_wstrb_o;

    logic        t_req, t_we, t_ready, t_mis, t_err;
    logic [31:0] t_addr, t_wdata, t_valm;
    logic [3:0]  t_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst(rst),
        .execute_vaild_i(execute_vaild_i), .ED_mem_rd_i(ED_mem_rd_i), .ED_mem_wr_i(ED_mem_wr_i),
        .ED_addr_i(ED_addr_i), .ED_wdata_i(ED_wdata_i), .ED_size_i(ED_size_i),
        .ED_unsigned_i(ED_unsigned_i), .write_back_allow_in_i(write_back_allow_in_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .memory_ready_o(memory_ready_o), .M_valM_o(M_valM_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(4)) dut_to (
        .clk_i(clk_i), .rst(rst),
        .execute_vaild_i(execute_vaild_i), .ED_mem_rd_i(ED_mem_rd_i), .ED_mem_wr_i(ED_mem_wr_i),
        .ED_addr_i(ED_addr_i), .ED_wdata_i(ED_wdata_i), .ED_size_i(ED_size_i),
        .ED_unsigned_i(ED_unsigned_i), .write_back_allow_in_i(write_back_allow_in_i),
        .bus_req_o(t_req), .bus_we_o(t_we), .bus_addr_o(t_addr),
        .bus_wdata_o(t_wdata), .bus_wstrb_o(t_wstrb),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .memory_ready_o(t_ready), .M_valM_o(t_valm),
        .misalign_o(t_mis), .bus_err_o(t_err)
    );

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        exp_ready;
        logic        exp_mis;
    } idle_vec_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } st_vec_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic        uns;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    idle_vec_t iv[9];
    st_vec_t   sv[4];
    ld_vec_t   lv[9];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an instruction, let it be captured, then scramble the ED_* inputs.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic uns);
        execute_vaild_i = 1'b1;
        ED_mem_rd_i     = rd;
        ED_mem_wr_i     = wr;
        ED_size_i       = size;
        ED_addr_i       = addr;
        ED_wdata_i      = wdata;
        ED_unsigned_i   = uns;
        tick();
        execute_vaild_i = 1'b0;
        ED_mem_rd_i     = 1'b0;
        ED_mem_wr_i     = 1'b0;
        ED_size_i       = 2'b11;
        ED_addr_i       = 32'hDEAD_BEEF;
        ED_wdata_i      = 32'hFFFF_FFFF;
        ED_unsigned_i   = 1'b1;
    endtask

    task automatic release_done();
        write_back_allow_in_i = 1'b1;
        tick();
        write_back_allow_in_i = 1'b0;
    endtask

    initial begin
        iv[0] = '{1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0201, 1'b1, 1'b0};
        iv[1] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0003, 1'b1, 1'b0};
        iv[2] = '{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0201, 1'b1, 1'b1};
        iv[3] = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_0003, 1'b1, 1'b1};
        iv[4] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_0002, 1'b0, 1'b0};
        iv[5] = '{1'b1, 1'b1, 1'b0, 2'b11, 32'h0000_0000, 1'b1, 1'b1};
        iv[6] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_0002, 1'b1, 1'b1};
        iv[7] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'h0000_0003, 1'b0, 1'b0};
        iv[8] = '{1'b1, 1'b1, 1'b0, 2'b10, 32'h0000_0004, 1'b0, 1'b0};

        sv[0] = '{2'b00, 32'h0000_0011, 32'h1122_3344, 4'b0010, 32'h4444_4444};
        sv[1] = '{2'b00, 32'h0000_0013, 32'h1122_3344, 4'b1000, 32'h4444_4444};
        sv[2] = '{2'b01, 32'h0000_0010, 32'h1122_3344, 4'b0011, 32'h3344_3344};
        sv[3] = '{2'b10, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h1122_3344};

        lv[0] = '{2'b00, 32'h0000_0040, 1'b0, 32'h80FF_1234, 32'h0000_0034};
        lv[1] = '{2'b00, 32'h0000_0041, 1'b0, 32'h80FF_1234, 32'h0000_0012};
        lv[2] = '{2'b00, 32'h0000_0042, 1'b0, 32'h80FF_1234, 32'hFFFF_FFFF};
        lv[3] = '{2'b00, 32'h0000_0042, 1'b1, 32'h80FF_1234, 32'h0000_00FF};
        lv[4] = '{2'b00, 32'h0000_0043, 1'b0, 32'h80FF_1234, 32'hFFFF_FF80};
        lv[5] = '{2'b01, 32'h0000_0040, 1'b0, 32'h80FF_1234, 32'h0000_1234};
        lv[6] = '{2'b01, 32'h0000_0042, 1'b0, 32'h80FF_1234, 32'hFFFF_80FF};
        lv[7] = '{2'b01, 32'h0000_0042, 1'b1, 32'h80FF_1234, 32'h0000_80FF};
        lv[8] = '{2'b10, 32'h0000_0040, 1'b0, 32'h80FF_1234, 32'h80FF_1234};

        rst = 1'b1;
        execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
        ED_addr_i = '0; ED_wdata_i = '0; ED_size_i = '0; ED_unsigned_i = 1'b0;
        write_back_allow_in_i = 1'b0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_valm", M_valM_o, 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_wstrb", 32'(bus_wstrb_o), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(memory_ready_o), 32'd1);

        // IDLE decode: ready/misalign combinational, no bus request
        for (int i = 0; i < 9; i++) begin
            tick();
            execute_vaild_i = iv[i].valid;
            ED_mem_rd_i     = iv[i].rd;
            ED_mem_wr_i     = iv[i].wr;
            ED_size_i       = iv[i].size;
            ED_addr_i       = iv[i].addr;
            #1;
            chk($sformatf("idle_ready[%0d]", i), 32'(memory_ready_o), 32'(iv[i].exp_ready));
            chk($sformatf("idle_mis[%0d]", i), 32'(misalign_o), 32'(iv[i].exp_mis));
            chk($sformatf("idle_req[%0d]", i), 32'(bus_req_o), 32'd0);
            execute_vaild_i = 1'b0;
            ED_mem_rd_i     = 1'b0;
            ED_mem_wr_i     = 1'b0;
        end

        // Misaligned LW held across an edge stays in IDLE without a request
        tick();
        execute_vaild_i = 1'b1; ED_mem_rd_i = 1'b1; ED_size_i = 2'b10; ED_addr_i = 32'h0000_0201;
        tick();
        chk("lw_mis_req", 32'(bus_req_o), 32'd0);
        chk("lw_mis_ready", 32'(memory_ready_o), 32'd1);
        chk("lw_mis_flag", 32'(misalign_o), 32'd1);
        execute_vaild_i = 1'b0; ED_mem_rd_i = 1'b0;

        // LB 0x103, grant in the 3rd REQ cycle, rvalid one cycle later
        tick();
        issue(1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h0, 1'b0);
        chk("lb_req", 32'(bus_req_o), 32'd1);
        chk("lb_addr", bus_addr_o, 32'h0000_0100);
        chk("lb_we", 32'(bus_we_o), 32'd0);
        tick(); tick();
        chk("lb_req_held", 32'(bus_req_o), 32'd1);
        chk("lb_addr_held", bus_addr_o, 32'h0000_0100);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("lb_wait_req", 32'(bus_req_o), 32'd0);
        chk("lb_wait_ready", 32'(memory_ready_o), 32'd0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h80FF_1234;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk("lb_done_ready", 32'(memory_ready_o), 32'd1);
        chk("lb_valm", M_valM_o, 32'hFFFF_FF80);
        chk("lb_err", 32'(bus_err_o), 32'd0);
        release_done();
        chk("lb_idle_ready", 32'(memory_ready_o), 32'd1);

        // SH 0x202, grant on REQ entry
        issue(1'b0, 1'b1, 2'b01, 32'h0000_0202, 32'hABCD_5678, 1'b0);
        chk("sh_wstrb", 32'(bus_wstrb_o), 32'h0000_000C);
        chk("sh_wdata", bus_wdata_o, 32'h5678_5678);
        chk("sh_we", 32'(bus_we_o), 32'd1);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("sh_done_ready", 32'(memory_ready_o), 32'd1);
        chk("sh_valm", M_valM_o, 32'd0);
        release_done();

        // Store lanes/strobes
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, sv[i].size, sv[i].addr, sv[i].wdata, 1'b0);
            chk($sformatf("st_wstrb[%0d]", i), 32'(bus_wstrb_o), 32'(sv[i].exp_wstrb));
            chk($sformatf("st_wdata[%0d]", i), bus_wdata_o, sv[i].exp_wdata);
            chk($sformatf("st_addr[%0d]", i), bus_addr_o, 32'h0000_0010);
            bus_gnt_i = 1'b1;
            tick();
            bus_gnt_i = 1'b0;
            chk($sformatf("st_valm[%0d]", i), M_valM_o, 32'd0);
            release_done();
        end

        // Load formatting, grant and rvalid together
        for (int i = 0; i < 9; i++) begin
            issue(1'b1, 1'b0, lv[i].size, lv[i].addr, 32'h0, lv[i].uns);
            bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = lv[i].rdata;
            tick();
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
            chk($sformatf("ld_ready[%0d]", i), 32'(memory_ready_o), 32'd1);
            chk($sformatf("ld_valm[%0d]", i), M_valM_o, lv[i].exp);
            release_done();
        end

        // LHU 0x002, held in DONE for 3 cycles, then async reset in DONE
        issue(1'b1, 1'b0, 2'b01, 32'h0000_0002, 32'h0, 1'b1);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h9ABC_0000;
        tick();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk("lhu_valm", M_valM_o, 32'h0000_9ABC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("lhu_hold_ready[%0d]", i), 32'(memory_ready_o), 32'd1);
            chk($sformatf("lhu_hold_valm[%0d]", i), M_valM_o, 32'h0000_9ABC);
        end
        rst = 1'b1;
        #1;
        chk("rst_done_valm", M_valM_o, 32'd0);
        chk("rst_done_addr", bus_addr_o, 32'd0);
        tick();
        rst = 1'b0;

        // Reset pulsed in WAIT, then a late rvalid
        tick();
        issue(1'b1, 1'b0, 2'b10, 32'h0000_0300, 32'h0, 1'b0);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("wait_ready", 32'(memory_ready_o), 32'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("rst_wait_ready", 32'(memory_ready_o), 32'd1);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk("late_rvalid_ready", 32'(memory_ready_o), 32'd1);
        chk("late_rvalid_valm", M_valM_o, 32'd0);
        chk("late_rvalid_req", 32'(bus_req_o), 32'd0);

        // Timeout with TIMEOUT=4: no grant for 3 cycles, grant+rvalid on the abort cycle
        issue(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0, 1'b0);
        tick(); tick(); tick();
        chk("to_still_req", 32'(t_req), 32'd1);
        chk("to_not_ready", 32'(t_ready), 32'd0);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        chk("to_ready", 32'(t_ready), 32'd1);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_valm", t_valm, 32'd0);
        chk("to_req_drop", 32'(t_req), 32'd0);
        release_done();
        chk("to_idle_ready", 32'(t_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
